// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, byte-enable width and wait-counter width.
package dmem_pkg;

    localparam int BE_W  = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous byte-enabled write, synchronous read, no reset.
// Ports: clk, wr_en/rd_en strobes, word addr, wdata, be (per byte), rdata.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [BE_W-1:0] be,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    // rdata only moves on rd_en, so it holds while a response is pending
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, responds.
// Ports: clk1, reset1, req_{valid,ready,we,addr,wdata,be}, rsp_{valid,ready,rdata,err}.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int addr_data_width = 32,
    parameter int DEPTH_WORDS     = 256,
    parameter int WAIT_CYCLES     = 2
) (
    input  logic                       clk1,
    input  logic                       reset1,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [addr_data_width-1:0] req_addr,
    input  logic [addr_data_width-1:0] req_wdata,
    input  logic [BE_W-1:0]            req_be,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [addr_data_width-1:0] rsp_rdata,
    output logic                       rsp_err
);

    localparam int W  = addr_data_width;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             lat_we;
    logic [W-1:0]     lat_addr;
    logic [W-1:0]     lat_wdata;
    logic [BE_W-1:0]  lat_be;
    logic             err_q;
    logic             accept;
    logic             access;
    logic             addr_err;
    logic             wr_en;
    logic             rd_en;
    logic [W-1:0]     arr_rdata;

    // Misaligned, or word index beyond the array
    assign addr_err = (lat_addr[1:0] != 2'b00) ||
                      ({2'b00, lat_addr[W-1:2]} >= W'(DEPTH_WORDS));

    assign wr_en = access & lat_we & ~addr_err;
    assign rd_en = access & ~lat_we & ~addr_err;

    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        access    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = '0;
        // Array output register is only loaded on a good read
        if (rsp_valid && !lat_we && !err_q) begin
            rsp_rdata = arr_rdata;
        end
    end

    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= CNT_W'(WAIT_CYCLES);
            end
            if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                err_q <= addr_err;
            end
        end
    end

    dmem_array #(
        .DW    (W),
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk1),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .addr  (lat_addr[AW+1:2]),
        .wdata (lat_wdata),
        .be    (lat_be),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=2 and a WAIT_CYCLES=0 copy).
// Each task drives one scenario and checks against hand-computed values.
module tb_dmem_responder;

    logic        clk;
    logic        reset1;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        w_reset;
    logic        w_valid;
    logic        w_req_ready;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic        w_rsp_valid;
    logic        w_rsp_ready;
    logic [31:0] w_rdata;
    logic        w_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .addr_data_width (32),
        .DEPTH_WORDS     (256),
        .WAIT_CYCLES     (2)
    ) dut (
        .clk1      (clk),
        .reset1    (reset1),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(
        .addr_data_width (32),
        .DEPTH_WORDS     (256),
        .WAIT_CYCLES     (0)
    ) dut0 (
        .clk1      (clk),
        .reset1    (w_reset),
        .req_valid (w_valid),
        .req_ready (w_req_ready),
        .req_we    (w_we),
        .req_addr  (w_addr),
        .req_wdata (w_wdata),
        .req_be    (w_be),
        .rsp_valid (w_rsp_valid),
        .rsp_ready (w_rsp_ready),
        .rsp_rdata (w_rdata),
        .rsp_err   (w_err)
    );

    always #5 clk = ~clk;

    // One full transaction with rsp_ready held high; inputs are scrambled
    // right after acceptance. lat = edges from accept to rsp_valid.
    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        logic ok;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        rsp_ready = 1'b1;
        ok        = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = ~be;
        lat       = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!ok) lat = 99;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", rsp_err); end
        @(negedge clk);
        reset1  = 1'b0;
        w_reset = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr10_err got %b exp 0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr10_rdata got %h exp 0", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr10_latency got %0d exp 3", lat); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd10 got %h exp deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd10_err got %b exp 0", er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd10_latency got %0d exp 3", lat); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be0001 got %h exp deadbeaa", rd); end
        xact(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL be0000_err got %b exp 0", er); end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be0000 got %h exp deadbeaa", rd); end
        xact(1'b1, 32'h10, 32'h55660000, 4'b1100, rd, er, lat);
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h5566BEAA) begin errors++; $display("FAIL be1100 got %h exp 5566beaa", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
        xact(1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rd12_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd12_rdata got %h exp 0", rd); end
        xact(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL rd400_err got %b exp 1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd400_rdata got %h exp 0", rd); end
        xact(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr400_err got %b exp 1", er); end
        xact(1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rd0_intact got %h exp 0badf00d", rd); end
        xact(1'b1, 32'h11, 32'h0, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr11_err got %b exp 1", er); end
        xact(1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h5566BEAA) begin errors++; $display("FAIL rd10_intact got %h exp 5566beaa", rd); end
        xact(1'b1, 32'h3FC, 32'h11223344, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr3fc_err got %b exp 0", er); end
        xact(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL rd3fc got %h exp 11223344", rd); end
    endtask

    task automatic test_stall();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'hF;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        // A competing write stays valid for the whole stall
        req_we    = 1'b1;
        req_addr  = 32'h3FC;
        req_wdata = 32'h0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_rsp_timeout got %b exp 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 32'h5566BEAA) begin errors++; $display("FAIL stall_rdata[%0d] got %h exp 5566beaa", i, rsp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d] got %b exp 0", i, req_ready); end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid got %b exp 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", req_ready); end
        xact(1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL stall_no_write got %h exp 11223344", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset1 = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL abort_err got %b exp 0", rsp_err); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset1 = 1'b0;
        xact(1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_rd20 got %h exp cafef00d", rd); end
    endtask

    task automatic test_wait0();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            w_valid     = 1'b1;
            w_we        = (k == 0);
            w_addr      = 32'h8;
            w_wdata     = 32'hA5A55A5A;
            w_be        = 4'hF;
            w_rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            w_valid = 1'b0;
            w_wdata = 32'h0;
            checks++; if (w_rsp_valid !== 1'b0) begin errors++; $display("FAIL w0_e0_valid[%0d] got %b exp 0", k, w_rsp_valid); end
            @(posedge clk);
            #1;
            checks++; if (w_rsp_valid !== 1'b1) begin errors++; $display("FAIL w0_e1_valid[%0d] got %b exp 1", k, w_rsp_valid); end
            checks++; if (w_err !== 1'b0) begin errors++; $display("FAIL w0_err[%0d] got %b exp 0", k, w_err); end
            if (k == 1) begin
                checks++; if (w_rdata !== 32'hA5A55A5A) begin errors++; $display("FAIL w0_rdata got %h exp a5a55a5a", w_rdata); end
            end
            @(posedge clk);
            #1;
            checks++; if (w_req_ready !== 1'b1) begin errors++; $display("FAIL w0_idle[%0d] got %b exp 1", k, w_req_ready); end
        end
    endtask

    initial begin
        clk         = 1'b0;
        reset1      = 1'b1;
        w_reset     = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_be      = 4'h0;
        rsp_ready   = 1'b1;
        w_valid     = 1'b0;
        w_we        = 1'b0;
        w_addr      = 32'h0;
        w_wdata     = 32'h0;
        w_be        = 4'h0;
        w_rsp_ready = 1'b1;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_errors();
        test_stall();
        test_reset_abort();
        test_wait0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
